// File: rtl/seg7_capture_decoder_pkg.sv
// seg7_capture_decoder_pkg: state encoding and hex segment table for the 7-segment capture path
package seg7_capture_decoder_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, LOCKED = 2'd1, FAULT = 2'd2} state_t;
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/seg7_to_bin.sv
// seg7_to_bin: combinational segment pattern to hex digit decode with legality flag
module seg7_to_bin
  import seg7_capture_decoder_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       legal
);
  always_comb begin
    digit = '0;
    legal = 1'b0;
    for (int i = 0; i < 16; i++)
      if (pattern == SEG_TABLE[i]) begin
        digit = 4'(i);
        legal = 1'b1;
      end
  end
endmodule

// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder: sync, glitch-filter and decode a 7-segment bus, classifying digit steps
module seg7_capture_decoder
  import seg7_capture_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter bit ACTIVE_LOW_SEG = 1'b0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [6:0] seg_in,
  output logic [3:0] digit_out,
  output logic       digit_valid,
  output logic       illegal,
  output logic       new_digit,
  output logic       dir_up,
  output logic       dir_down,
  output logic       step_err
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE = CW'(STABLE_CYCLES);
  logic [6:0] p, s1, s2, cand, acc;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0] dec, digit_nxt;
  logic legal, accept, step_chk, up_nxt, down_nxt;
  state_t state, state_nxt;
  assign p = ACTIVE_LOW_SEG ? ~seg_in : seg_in;
  seg7_to_bin u_dec (.pattern(s2), .digit(dec), .legal(legal));
  always_comb begin
    cnt_nxt   = s2 != cand ? CW'(1) : cnt == STABLE ? cnt : cnt + 1'b1;
    accept    = cnt_nxt == STABLE && s2 != acc;
    state_nxt = accept ? (legal ? LOCKED : FAULT) : state;
    digit_nxt = accept && legal ? dec : digit_out;
    step_chk  = accept && legal && state == LOCKED;
    up_nxt    = step_chk && dec == digit_out + 4'd1;
    down_nxt  = step_chk && dec == digit_out - 4'd1;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      s1          <= '0;
      s2          <= '0;
      cand        <= '0;
      acc         <= '0;
      cnt         <= '0;
      state       <= EMPTY;
      digit_out   <= '0;
      digit_valid <= 1'b0;
      illegal     <= 1'b0;
      new_digit   <= 1'b0;
      dir_up      <= 1'b0;
      dir_down    <= 1'b0;
      step_err    <= 1'b0;
    end else begin
      s1          <= p;
      s2          <= s1;
      cand        <= s2;
      cnt         <= cnt_nxt;
      acc         <= accept ? s2 : acc;
      state       <= state_nxt;
      digit_out   <= digit_nxt;
      digit_valid <= state_nxt == LOCKED;
      illegal     <= state_nxt == FAULT;
      new_digit   <= accept && legal;
      dir_up      <= up_nxt;
      dir_down    <= down_nxt;
      step_err    <= step_chk && !up_nxt && !down_nxt;
    end
  end
endmodule

// File: tb/tb_seg7_capture_decoder.sv
// tb_seg7_capture_decoder: randomized and directed self-check of two decoder variants against a behavioural model
module tb_seg7_capture_decoder;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic [6:0] seg_in = '0;
  logic [3:0] digit_out [2];
  logic digit_valid [2], illegal [2], new_digit [2], dir_up [2], dir_down [2], step_err [2];
  int errors = 0, checks = 0;
  bit run = 1'b0;
  int up_cnt = 0, dn_cnt = 0, err_cnt = 0, new_cnt = 0;
  int S [2] = '{4, 2};
  bit AL [2] = '{1'b0, 1'b1};
  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [6:0] m_s1 [2], m_s2 [2], m_acc [2];
  logic [6:0] h [2][8];
  int n [2], m_state [2], m_dig [2];
  bit m_new [2], m_up [2], m_dn [2], m_err [2];

  always #5 clk = ~clk;

  seg7_capture_decoder #(.STABLE_CYCLES(4), .ACTIVE_LOW_SEG(1'b0)) dut (
    .clk(clk), .clr(clr), .seg_in(seg_in), .digit_out(digit_out[0]), .digit_valid(digit_valid[0]),
    .illegal(illegal[0]), .new_digit(new_digit[0]), .dir_up(dir_up[0]), .dir_down(dir_down[0]),
    .step_err(step_err[0]));
  seg7_capture_decoder #(.STABLE_CYCLES(2), .ACTIVE_LOW_SEG(1'b1)) dut_n (
    .clk(clk), .clr(clr), .seg_in(seg_in), .digit_out(digit_out[1]), .digit_valid(digit_valid[1]),
    .illegal(illegal[1]), .new_digit(new_digit[1]), .dir_up(dir_up[1]), .dir_down(dir_down[1]),
    .step_err(step_err[1]));

  function automatic int lookup(logic [6:0] pat);
    for (int i = 0; i < 16; i++) if (tbl[i] == pat) return i;
    return -1;
  endfunction

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic model_step(int i);
    logic [6:0] pin;
    bit stable;
    int d;
    m_new[i] = 0; m_up[i] = 0; m_dn[i] = 0; m_err[i] = 0;
    if (clr) begin
      m_s1[i] = '0; m_s2[i] = '0; m_acc[i] = '0;
      n[i] = 0; m_state[i] = 0; m_dig[i] = 0;
    end else begin
      pin = AL[i] ? ~seg_in : seg_in;
      for (int j = 7; j > 0; j--) h[i][j] = h[i][j-1];
      h[i][0] = m_s2[i];
      if (n[i] < 8) n[i]++;
      m_s2[i] = m_s1[i];
      m_s1[i] = pin;
      stable = n[i] >= S[i];
      for (int j = 0; j < S[i]; j++) if (h[i][j] != h[i][0]) stable = 0;
      if (stable && h[i][0] != m_acc[i]) begin
        m_acc[i] = h[i][0];
        d = lookup(h[i][0]);
        if (d < 0) m_state[i] = 2;
        else begin
          if (m_state[i] == 1) begin
            if (d == (m_dig[i] + 1) % 16) m_up[i] = 1;
            else if (d == (m_dig[i] + 15) % 16) m_dn[i] = 1;
            else m_err[i] = 1;
          end
          m_dig[i] = d;
          m_new[i] = 1;
          m_state[i] = 1;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    up_cnt  += int'(dir_up[0]);
    dn_cnt  += int'(dir_down[0]);
    err_cnt += int'(step_err[0]);
    new_cnt += int'(new_digit[0]);
  end

  always @(negedge clk)
    if (run)
      for (int i = 0; i < 2; i++)
        chk($sformatf("outputs[%0d] {dig,val,ill,new,up,dn,err}", i),
            int'({digit_out[i], digit_valid[i], illegal[i], new_digit[i], dir_up[i], dir_down[i], step_err[i]}),
            int'({4'(m_dig[i]), m_state[i] == 1, m_state[i] == 2, m_new[i], m_up[i], m_dn[i], m_err[i]}));

  task automatic hold(logic [6:0] pat, int cyc);
    seg_in = pat;
    repeat (cyc) @(negedge clk);
  endtask

  initial begin
    int u0, d0, e0, n0;
    logic [6:0] pat;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    chk("reset digit_valid", int'(digit_valid[0]), 0);
    chk("reset digit_out", int'(digit_out[0]), 0);
    clr = 1'b0;
    hold(7'h3F, 5);
    chk("t1 no accept at edge 5", int'(new_digit[0]), 0);
    @(negedge clk);
    chk("t1 new_digit at edge 6", int'(new_digit[0]), 1);
    chk("t1 digit 0", int'(digit_out[0]), 0);
    chk("t1 valid", int'(digit_valid[0]), 1);
    chk("t1 no dir pulse", int'(dir_up[0] | dir_down[0] | step_err[0]), 0);
    hold(7'h3F, 6);
    u0 = up_cnt;
    for (int k = 1; k <= 16; k++) hold(tbl[k % 16], 10);
    chk("t2 up sweep pulses", up_cnt - u0, 16);
    d0 = dn_cnt;
    for (int k = 15; k >= 0; k--) hold(tbl[k], 10);
    chk("t2 down sweep pulses", dn_cnt - d0, 16);
    hold(tbl[4], 10);
    e0 = err_cnt;
    hold(7'h7F, 10);
    chk("t3 step_err 4->8", err_cnt - e0, 1);
    chk("t3 digit 8", int'(digit_out[0]), 8);
    n0 = new_cnt;
    hold(7'h06, 1);
    hold(7'h7F, 10);
    chk("t3 glitch ignored", new_cnt - n0, 0);
    chk("t3 digit still 8", int'(digit_out[0]), 8);
    hold(7'h00, 10);
    chk("t4 blank illegal", int'(illegal[0]), 1);
    chk("t4 blank not valid", int'(digit_valid[0]), 0);
    hold(7'h55, 10);
    chk("t4 digit held", int'(digit_out[0]), 8);
    u0 = up_cnt; d0 = dn_cnt; e0 = err_cnt; n0 = new_cnt;
    hold(7'h6D, 10);
    chk("t4 digit 5", int'(digit_out[0]), 5);
    chk("t4 one new_digit", new_cnt - n0, 1);
    chk("t4 no dir after fault", (up_cnt - u0) + (dn_cnt - d0) + (err_cnt - e0), 0);
    hold(~7'h5B, 10);
    chk("t5 active-low digit 2", int'(digit_out[1]), 2);
    chk("t5 active-low valid", int'(digit_valid[1]), 1);
    hold(7'h06, 3);
    clr = 1'b1;
    @(negedge clk);
    chk("t5 clr digit_out", int'(digit_out[0]), 0);
    chk("t5 clr valid/illegal", int'(digit_valid[1] | illegal[0]), 0);
    clr = 1'b0;
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: pat = tbl[$urandom_range(0, 15)];
        6, 7: pat = 7'($urandom);
        default: pat = ~tbl[$urandom_range(0, 15)];
      endcase
      clr = ($urandom_range(0, 39) == 0);
      hold(pat, $urandom_range(1, 7));
      clr = 1'b0;
    end
    hold(seg_in, 8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
